// File: rtl/adder72_seq_ctrl.sv
// adder72_seq_ctrl: 72-bit add over three cycles on one shared 24-bit adder, valid/ready on both sides.
// Optional signed-overflow output ovf when ADDER72_SEQ_OVF_EN is defined.
module adder24 (
   input  logic [23:0] a,
   input  logic [23:0] b,
   input  logic        ci,
   output logic [23:0] s,
   output logic        co
);
   assign {co, s} = a + b + {23'd0, ci};
endmodule

module adder72_seq_ctrl #(
   parameter int SLICE_W    = 24,
   parameter int NUM_SLICES = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [SLICE_W*NUM_SLICES-1:0]   A,
   input  logic [SLICE_W*NUM_SLICES-1:0]   B,
   input  logic                            c0,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [SLICE_W*NUM_SLICES-1:0]   S,
   output logic                            c72,
   output logic                            busy
`ifdef ADDER72_SEQ_OVF_EN
   ,output logic                           ovf
`endif
);
   localparam int W  = SLICE_W * NUM_SLICES;
   localparam int CW = $clog2(NUM_SLICES);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic cy_q, cy_d, c0_q, c0_d, c72_q, c72_d;
   logic [W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic [SLICE_W-1:0] a_sl, b_sl, sum_sl;
   logic cin_sl, cout_sl, last;
`ifdef ADDER72_SEQ_OVF_EN
   logic ovf_q, ovf_d;
   assign ovf = ovf_q;
`endif
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NUM_SLICES; i++)
         if (cnt_q == CW'(i)) begin
            a_sl = a_q[i*SLICE_W +: SLICE_W];
            b_sl = b_q[i*SLICE_W +: SLICE_W];
         end
   end
   assign cin_sl = (cnt_q == '0) ? c0_q : cy_q;
   assign last   = (cnt_q == CW'(NUM_SLICES-1));
   adder24 u_add (.a(a_sl), .b(b_sl), .ci(cin_sl), .s(sum_sl), .co(cout_sl));
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      c0_d    = c0_q;
      c72_d   = c72_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
`ifdef ADDER72_SEQ_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = A;
            b_d     = B;
            c0_d    = c0;
            s_d     = '0;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            for (int i = 0; i < NUM_SLICES; i++)
               if (cnt_q == CW'(i)) s_d[i*SLICE_W +: SLICE_W] = sum_sl;
            cy_d = cout_sl;
            if (last) begin
               c72_d   = cout_sl;
`ifdef ADDER72_SEQ_OVF_EN
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_sl[SLICE_W-1] != a_q[W-1]);
`endif
               state_d = DONE;
            end else cnt_d = cnt_q + 1'b1;
         end
         DONE: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         c0_q    <= 1'b0;
         c72_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
`ifdef ADDER72_SEQ_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         c0_q    <= c0_d;
         c72_q   <= c72_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
`ifdef ADDER72_SEQ_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign S         = s_q;
   assign c72       = c72_q;
endmodule

// File: tb/tb_adder72_seq_ctrl.sv
// tb_adder72_seq_ctrl: scoreboard bench for the sequential 72-bit adder.
`timescale 1ns/1ps
module tb_adder72_seq_ctrl;
   logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, c0 = 1'b0;
   logic in_ready, out_valid, c72, busy;
   logic [71:0] A = '0, B = '0, S;
`ifdef ADDER72_SEQ_OVF_EN
   logic ovf;
`endif
   typedef struct {logic [71:0] s; logic c; logic o;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;

   adder72_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .c0(c0), .out_valid(out_valid), .out_ready(out_ready),
      .S(S), .c72(c72), .busy(busy)
`ifdef ADDER72_SEQ_OVF_EN
      ,.ovf(ovf)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [71:0] rnd72();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic accept(input logic [71:0] a, input logic [71:0] b, input logic c);
      logic [72:0] sum;
      @(negedge clk);
      A = a; B = b; c0 = c; in_valid = 1'b1;
      chk("in_ready", in_ready, 1);
      @(posedge clk);
      sum = {1'b0, a} + {1'b0, b} + {72'd0, c};
      q.push_back('{s: sum[71:0], c: sum[72], o: (a[71] == b[71]) && (sum[71] != a[71])});
      #1 in_valid = 1'b0;
      A = rnd72(); B = rnd72(); c0 = ~c;
   endtask

   task automatic finish(input int hold);
      int n = 0;
      exp_t e;
      do begin @(negedge clk); n++; end while (!out_valid && n < 8);
      chk("latency", n, 4);
      if (q.size() == 0) begin chk("queue_empty", 0, 1); return; end
      e = q.pop_front();
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_in_ready", in_ready, 0);
         chk("hold_s", S, e.s);
         chk("hold_c72", c72, e.c);
         @(negedge clk);
      end
      out_ready = 1'b1;
      chk("out_valid", out_valid, 1);
      chk("sum", S, e.s);
      chk("c72", c72, e.c);
`ifdef ADDER72_SEQ_OVF_EN
      chk("ovf", ovf, e.o);
`endif
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("valid_drop", out_valid, 0);
      chk("ready_back", in_ready, 1);
   endtask

   task automatic op(input logic [71:0] a, input logic [71:0] b, input logic c, input int hold);
      accept(a, b, c);
      finish(hold);
   endtask

   initial begin
      int nrand;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_s", S, 0);
      chk("rst_c72", c72, 0);
      rst_n = 1'b1;
      op(72'h1, 72'h1, 1'b0, 0);
      op({72{1'b1}}, 72'h0, 1'b1, 0);
      op(72'h000000_000000_FFFFFF, 72'h1, 1'b0, 0);
      op(72'h123456_789ABC_DEF012, 72'hFEDCBA_987654_321001, 1'b1, 10);
      accept(72'hABCDEF_ABCDEF_ABCDEF, 72'h111111_111111_111111, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("ar_in_ready", in_ready, 1);
      chk("ar_out_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_s", S, 0);
      chk("ar_c72", c72, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      op(72'd5, 72'd7, 1'b0, 0);
      op(72'h7F_FFFF_FFFF_FFFF_FFFF, 72'h1, 1'b0, 0);
      op(72'h80_0000_0000_0000_0000, 72'h80_0000_0000_0000_0000, 1'b0, 2);
      out_ready = 1'b1;
      @(negedge clk);
      chk("idle_ready_ignored", busy, 0);
      out_ready = 1'b0;
`ifdef ADDER72_SEQ_OVF_EN
      nrand = 10000;
`else
      nrand = 1000;
`endif
      for (int i = 0; i < nrand; i++) op(rnd72(), rnd72(), 1'($urandom), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
